// File: rtl/regfile_read_arbiter_if.sv
// Bundle of signals between the requesters, the shared register read port and
// the read arbiter.
//   slave  : the arbiter side (takes requests and port data; drives grant,
//            port select and responses)
//   master : the requester/port side (the mirror image of slave)
interface regfile_read_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*ADDR_W-1:0] req_burst;
    logic [NUM_REQ-1:0]        req_ready;
    logic [ADDR_W-1:0]         port_select;
    logic [DATA_W-1:0]         port_data;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_data;
    logic                      resp_last;
    logic                      busy;

    modport slave (
        input  req_valid, req_addr, req_burst, port_data,
        output req_ready, port_select, resp_valid, resp_data, resp_last, busy
    );

    modport master (
        output req_valid, req_addr, req_burst, port_data,
        input  req_ready, port_select, resp_valid, resp_data, resp_last, busy
    );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NUM_REQ
// requesters. A grant reads one register or a burst of consecutive registers
// (index wraps modulo 2**ADDR_W); data is returned registered to the owner.
// Ports:
//   clock  : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : slave modport of regfile_read_arbiter_if (requests, grant,
//            port select/data, responses, busy)
//
// state | meaning
// IDLE  | no grant in progress; req_ready offered to next requester in rr order
// BURST | port owned by 'owner'; one word returned per cycle
module regfile_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic clock,
    input  logic reset,
    regfile_read_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [ADDR_W-1:0]  remaining;
    logic [ADDR_W-1:0]  sel_r;
    logic [NUM_REQ-1:0] resp_valid_r;
    logic [DATA_W-1:0]  resp_data_r;
    logic               resp_last_r;
    logic               busy_r;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_found;
    logic [IDX_W:0]     cand;

    // Search upward from rr_ptr with wrap; the first valid requester wins.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        cand      = '0;
        if (state == IDLE) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
                if (cand >= (IDX_W+1)'(NUM_REQ))
                    cand = cand - (IDX_W+1)'(NUM_REQ);
                if (!gnt_found && bus.req_valid[cand[IDX_W-1:0]]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand[IDX_W-1:0];
                end
            end
            if (gnt_found)
                gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            remaining    <= '0;
            sel_r        <= '0;
            resp_valid_r <= '0;
            resp_data_r  <= '0;
            resp_last_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid_r <= '0;
                    resp_last_r  <= 1'b0;
                    if (gnt_found) begin
                        owner     <= gnt_idx;
                        sel_r     <= bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
                        remaining <= bus.req_burst[gnt_idx*ADDR_W +: ADDR_W];
                        rr_ptr    <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
                        busy_r    <= 1'b1;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    resp_data_r  <= bus.port_data;
                    resp_valid_r <= NUM_REQ'(1) << owner;
                    resp_last_r  <= (remaining == '0);
                    if (remaining == '0) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        remaining <= remaining - 1'b1;
                        // natural overflow gives the modulo 2**ADDR_W wrap
                        sel_r     <= sel_r + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = gnt;
    assign bus.port_select = sel_r;
    assign bus.resp_valid  = resp_valid_r;
    assign bus.resp_data   = resp_data_r;
    assign bus.resp_last   = resp_last_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: directed cases followed by random traffic,
// all checked against a transaction-level model that schedules each grant's
// select/response words by cycle number.
module tb_regfile_read_arbiter;
    localparam int N    = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int MAXC = 4000;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    regfile_read_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    regfile_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [DW-1:0] mem [32];
    assign bus.port_data = mem[bus.port_select];

    // expected registered outputs, indexed by cycle
    logic [N-1:0]  exp_v  [MAXC];
    logic [DW-1:0] exp_d  [MAXC];
    logic          exp_l  [MAXC];
    logic          exp_b  [MAXC];
    logic          exp_sv [MAXC];
    logic [AW-1:0] exp_s  [MAXC];

    int            cyc, m_rr, m_free;
    logic [DW-1:0] last_d;
    logic [AW-1:0] last_sel;
    bit            regs_ok;
    bit            pend   [N];
    bit            sticky [N];
    logic [AW-1:0] paddr  [N];
    logic [AW-1:0] pburst [N];
    int            passed, total;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, expv);
    endtask

    task automatic set_req(input int i, input int a, input int b);
        pend[i]   = 1'b1;
        paddr[i]  = AW'(a);
        pburst[i] = AW'(b);
    endtask

    task automatic clear_future();
        for (int c = cyc + 1; c < MAXC; c++) begin
            exp_v[c] = '0; exp_d[c] = '0; exp_l[c] = 1'b0;
            exp_b[c] = 1'b0; exp_sv[c] = 1'b0; exp_s[c] = '0;
        end
    endtask

    task automatic step(input bit rst);
        int       idx;
        bit       found;
        logic [N-1:0] exp_ready;
        @(negedge clock);
        if (regs_ok) begin
            if (exp_sv[cyc]) last_sel = exp_s[cyc];
            if (exp_v[cyc] != '0) last_d = exp_d[cyc];
            chk("resp_valid",  64'(bus.resp_valid),  64'(exp_v[cyc]));
            chk("resp_last",   64'(bus.resp_last),   64'(exp_l[cyc]));
            chk("resp_data",   64'(bus.resp_data),   64'(last_d));
            chk("busy",        64'(bus.busy),        64'(exp_b[cyc]));
            chk("port_select", 64'(bus.port_select), 64'(last_sel));
        end
        reset = rst;
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i] = pend[i];
            bus.req_addr[i*AW +: AW]  = paddr[i];
            bus.req_burst[i*AW +: AW] = pburst[i];
        end
        #1;
        exp_ready = '0;
        found     = 1'b0;
        idx       = 0;
        if (!rst && cyc >= m_free) begin
            for (int k = 0; k < N; k++)
                if (!found && pend[(m_rr + k) % N]) begin
                    found = 1'b1;
                    idx   = (m_rr + k) % N;
                end
        end
        if (found) begin
            exp_ready[idx] = 1'b1;
            for (int k = 0; k <= int'(pburst[idx]); k++) begin
                exp_sv[cyc+1+k] = 1'b1;
                exp_s[cyc+1+k]  = AW'((int'(paddr[idx]) + k) % 32);
                exp_b[cyc+1+k]  = 1'b1;
                exp_v[cyc+2+k]  = N'(1) << idx;
                exp_d[cyc+2+k]  = mem[(int'(paddr[idx]) + k) % 32];
                exp_l[cyc+2+k]  = (k == int'(pburst[idx]));
            end
            m_free = cyc + 2 + int'(pburst[idx]);
            m_rr   = (idx + 1) % N;
            if (!sticky[idx]) pend[idx] = 1'b0;
        end
        if (!rst && regs_ok)
            chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        if (rst) begin
            clear_future();
            m_rr     = 0;
            m_free   = cyc + 1;
            last_d   = '0;
            last_sel = '0;
            regs_ok  = 1'b1;
            for (int i = 0; i < N; i++) begin
                pend[i] = 1'b0; sticky[i] = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    initial begin
        passed = 0; total = 0; cyc = 0; m_rr = 0; m_free = 0;
        last_d = '0; last_sel = '0; regs_ok = 1'b0;
        reset = 1'b1;
        bus.req_valid = '0; bus.req_addr = '0; bus.req_burst = '0;
        for (int i = 0; i < 32; i++) mem[i] = DW'(i * 32'h11);
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; sticky[i] = 1'b0; paddr[i] = '0; pburst[i] = '0;
        end
        for (int c = 0; c < MAXC; c++) begin
            exp_v[c] = '0; exp_d[c] = '0; exp_l[c] = 1'b0;
            exp_b[c] = 1'b0; exp_sv[c] = 1'b0; exp_s[c] = '0;
        end
        step(1'b1);
        step(1'b1);

        // single read, 0x77 expected
        set_req(0, 7, 0);
        run(5);
        // wrapped burst 30,31,0,1
        set_req(1, 30, 3);
        run(8);
        // fairness: all held valid, single reads
        for (int i = 0; i < N; i++) begin
            set_req(i, 4 * i + 1, 0);
            sticky[i] = 1'b1;
        end
        run(12);
        for (int i = 0; i < N; i++) sticky[i] = 1'b0;
        run(10);
        // contention: req 0 raised mid-burst of req 2
        set_req(2, 4, 5);
        run(3);
        set_req(0, 9, 0);
        run(12);
        // full dump
        set_req(3, 12, 31);
        run(36);
        // reset during the third word of a burst
        set_req(1, 20, 7);
        run(4);
        step(1'b1);
        step(1'b0);
        set_req(0, 7, 0);
        run(5);

        // random traffic with random port contents
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        for (int it = 0; it < 1500; it++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 3) == 0)
                    set_req(i, $urandom_range(0, 31),
                            ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31)
                                                        : $urandom_range(0, 3));
            step($urandom_range(0, 399) == 0);
        end
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        run(40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
